// File: rtl/weight_memory_multibank.sv
// weight_memory_multibank: multi-bank weight store with streamed layer load and one-word-per-bank reads
module weight_memory_multibank #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 11,
  parameter int DATA_DEPTH  = 2048,
  parameter int NUM_BANKS   = 8,
  parameter int LAYER_IDX_W = 4,
  localparam int BW = $clog2(NUM_BANKS),
  localparam int CW = ADDR_WIDTH + BW + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            csen,
  input  logic                            load_start,
  input  logic [LAYER_IDX_W-1:0]          load_layer,
  input  logic [CW-1:0]                   load_len,
  input  logic                            load_valid,
  input  logic [DATA_WIDTH-1:0]           load_data,
  output logic                            load_ready,
  output logic                            load_busy,
  output logic                            load_done,
  output logic                            load_err,
  output logic                            layer_valid,
  output logic [LAYER_IDX_W-1:0]          active_layer,
  input  logic                            rd_en,
  input  logic [ADDR_WIDTH-1:0]           rd_addr,
  output logic                            rd_valid,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] rd_data,
  output logic                            rd_err
);
  localparam logic [CW-1:0] MAX_LEN = CW'(NUM_BANKS * DATA_DEPTH);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t                        state_q;
  logic [CW-1:0]                 len_q, k_q;
  logic [LAYER_IDX_W-1:0]        layer_q, active_layer_q;
  logic                          layer_valid_q, load_err_q, rd_valid_q, rd_err_q, we;
  logic [NUM_BANKS*DATA_WIDTH-1:0] raw;
  assign we           = !rst && state_q == LOAD && load_valid;
  assign load_ready   = state_q == LOAD;
  assign load_busy    = state_q == LOAD;
  assign load_done    = state_q == DONE;
  assign load_err     = load_err_q;
  assign layer_valid  = layer_valid_q;
  assign active_layer = active_layer_q;
  assign rd_valid     = rd_valid_q;
  assign rd_err       = rd_err_q;
  assign rd_data      = rd_valid_q ? raw : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      k_q            <= '0;
      len_q          <= '0;
      layer_q        <= '0;
      active_layer_q <= '0;
      layer_valid_q  <= 1'b0;
      load_err_q     <= 1'b0;
      rd_valid_q     <= 1'b0;
      rd_err_q       <= 1'b0;
    end else begin
      load_err_q <= 1'b0;
      rd_valid_q <= csen && rd_en && state_q == IDLE;
      rd_err_q   <= csen && rd_en && state_q != IDLE;
      case (state_q)
        IDLE: if (csen && load_start) begin
          if (load_len == '0 || load_len > MAX_LEN) load_err_q <= 1'b1;
          else begin
            len_q         <= load_len;
            layer_q       <= load_layer;
            k_q           <= '0;
            layer_valid_q <= 1'b0;
            state_q       <= LOAD;
          end
        end
        LOAD: if (load_valid) begin
          k_q <= k_q + 1'b1;
          if (k_q == len_q - 1'b1) begin
            state_q        <= DONE;
            layer_valid_q  <= 1'b1;
            active_layer_q <= layer_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // low counter bits pick the bank, the rest pick the row
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
    logic [DATA_WIDTH-1:0] q;
    always_ff @(posedge clk) begin
      if (we && k_q[BW-1:0] == BW'(b)) mem[k_q[BW+ADDR_WIDTH-1:BW]] <= load_data;
      q <= mem[rd_addr];
    end
    assign raw[b*DATA_WIDTH +: DATA_WIDTH] = q;
  end
endmodule

// File: tb/tb_weight_memory_multibank.sv
// tb_weight_memory_multibank: directed and randomized checks against an array model of the banks
module tb_weight_memory_multibank;
  localparam int DW = 8, AW = 11, DD = 2048, NB = 8, LW = 4, CW = AW + 3 + 1;
  logic clk = 0, rst = 0, csen = 0, load_start = 0, load_valid = 0, rd_en = 0;
  logic [LW-1:0] load_layer = '0;
  logic [CW-1:0] load_len = '0;
  logic [DW-1:0] load_data = '0;
  logic [AW-1:0] rd_addr = '0;
  logic load_ready, load_busy, load_done, load_err, layer_valid, rd_valid, rd_err;
  logic [LW-1:0] active_layer;
  logic [NB*DW-1:0] rd_data;
  int checks = 0, errors = 0;
  logic [DW-1:0] mdl [NB][DD];
  bit known [NB][DD];

  weight_memory_multibank dut (
    .clk(clk), .rst(rst), .csen(csen), .load_start(load_start), .load_layer(load_layer),
    .load_len(load_len), .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .load_busy(load_busy), .load_done(load_done), .load_err(load_err), .layer_valid(layer_valid),
    .active_layer(active_layer), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_read(input string tag, input logic [AW-1:0] a);
    logic [63:0] e, m;
    e = '0;
    m = '0;
    for (int b = 0; b < NB; b++) if (known[b][a]) begin
      e[b*DW +: DW] = mdl[b][a];
      m[b*DW +: DW] = '1;
    end
    chk({tag, "_valid"}, 64'(rd_valid), 64'd1);
    chk(tag, rd_data & m, e);
  endtask

  task automatic do_read(input string tag, input logic [AW-1:0] a);
    csen = 1; rd_en = 1; rd_addr = a;
    tick;
    rd_en = 0;
    expect_read(tag, a);
  endtask

  // mode: 0 no stalls, 1 valid pattern 1,0,0, 2 random stalls
  task automatic do_load(input string tag, input logic [LW-1:0] layer, input int len, input int mode,
                         input bit seq, input int rd_at, input int rst_after);
    int k = 0, cyc = 0;
    bit v, aborted = 0;
    csen = 1; load_start = 1; load_layer = layer; load_len = CW'(len);
    tick;
    load_start = 0;
    chk({tag, "_start_lv"}, 64'(layer_valid), 64'd0);
    while (k < len && cyc < 4 * len + 50) begin
      v = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 3 == 0) : ($urandom_range(0, 3) != 0);
      load_valid = v;
      load_data = seq ? DW'(k) : DW'($urandom);
      rd_en = cyc == rd_at;
      rd_addr = '0;
      load_start = cyc == rd_at;
      load_len = '0;
      chk({tag, "_flags"}, 64'({load_ready, load_busy, load_done}), 64'(3'b110));
      tick;
      if (v) begin
        mdl[k % NB][k / NB] = load_data;
        known[k % NB][k / NB] = 1;
        k++;
      end
      if (rd_en) begin
        chk({tag, "_rderr"}, 64'({rd_err, rd_valid}), 64'(2'b10));
        chk({tag, "_rddata"}, rd_data, 64'd0);
        chk({tag, "_nostart_err"}, 64'(load_err), 64'd0);
      end
      rd_en = 0;
      load_start = 0;
      cyc++;
      if (rst_after > 0 && k == rst_after) begin
        rst = 1; load_valid = 0;
        tick;
        rst = 0;
        chk({tag, "_rst_ctl"}, 64'({load_ready, load_busy, load_done, load_err, layer_valid,
                                   active_layer, rd_valid, rd_err}), 64'd0);
        chk({tag, "_rst_data"}, rd_data, 64'd0);
        aborted = 1;
        break;
      end
    end
    load_valid = 0;
    if (!aborted) begin
      if (k != len) chk({tag, "_timeout"}, 64'(k), 64'(len));
      chk({tag, "_done"}, 64'({load_ready, load_busy, load_done}), 64'(3'b001));
      chk({tag, "_layer"}, 64'({layer_valid, active_layer}), 64'({1'b1, layer}));
      tick;
      chk({tag, "_idle"}, 64'({load_ready, load_busy, load_done}), 64'(3'b000));
      chk({tag, "_layer_hold"}, 64'({layer_valid, active_layer}), 64'({1'b1, layer}));
    end
  endtask

  initial begin
    int len;
    rst = 1;
    tick; tick;
    rst = 0;
    chk("reset_ctl", 64'({load_ready, load_busy, load_done, load_err, layer_valid, active_layer,
                          rd_valid, rd_err}), 64'd0);
    chk("reset_data", rd_data, 64'd0);
    // 1: basic load, sequential data
    do_load("t1", 4'd3, 16, 0, 1, -1, 0);
    do_read("t1_rd", 11'd1);
    chk("t1_rd_lit", rd_data, 64'h0F0E0D0C0B0A0908);
    tick;
    chk("t1_rd_drop", 64'({rd_valid, rd_err}), 64'd0);
    chk("t1_rd_zero", rd_data, 64'd0);
    // 2: stalled stream of 10 words
    do_load("t2", 4'd6, 10, 1, 1, -1, 0);
    do_read("t2_rd", 11'd1);
    chk("t2_rd_lit", rd_data, 64'h0F0E0D0C0B0A0908 & 64'hFFFFFFFFFFFF0000 | 64'h0908);
    // 3: illegal lengths
    load_start = 1; load_len = '0; load_layer = 4'd1;
    tick;
    load_start = 0;
    chk("t3_len0", 64'({load_err, load_busy, layer_valid, active_layer}), 64'({3'b101, 4'd6}));
    tick;
    chk("t3_len0_pulse", 64'(load_err), 64'd0);
    load_start = 1; load_len = CW'(16385);
    tick;
    load_start = 0;
    chk("t3_len_big", 64'({load_err, load_busy, layer_valid, active_layer}), 64'({3'b101, 4'd6}));
    tick;
    chk("t3_big_pulse", 64'({load_err, load_busy}), 64'd0);
    // csen low ignores both load_start and rd_en
    csen = 0; load_start = 1; load_len = CW'(4); rd_en = 1;
    tick;
    load_start = 0; rd_en = 0;
    chk("csen_off", 64'({load_busy, load_err, rd_valid, rd_err}), 64'd0);
    csen = 1;
    // 4: read during load, random data
    do_load("t4", 4'd2, 16, 0, 0, 2, 0);
    do_read("t4_rd0", 11'd0);
    do_read("t4_rd1", 11'd1);
    // 5: reset mid-load, then a full load
    do_load("t5a", 4'd9, 16, 0, 0, -1, 5);
    do_load("t5b", 4'd5, 20, 2, 0, -1, 0);
    for (int a = 0; a < 3; a++) do_read("t5_rd", AW'(a));
    // 6: back-to-back reads
    rd_en = 1; rd_addr = 11'd0;
    tick;
    rd_addr = 11'd1;
    expect_read("t6_a0", 11'd0);
    tick;
    rd_addr = 11'd0;
    expect_read("t6_a1", 11'd1);
    tick;
    rd_en = 0;
    expect_read("t6_a0b", 11'd0);
    tick;
    chk("t6_drop", 64'(rd_valid), 64'd0);
    chk("t6_zero", rd_data, 64'd0);
    // random loads and reads
    for (int i = 0; i < 4; i++) begin
      len = $urandom_range(1, 40);
      do_load("rnd", LW'($urandom), len, 2, 0, -1, 0);
      for (int j = 0; j < 3; j++) do_read("rnd_rd", AW'($urandom_range(0, (len - 1) / NB)));
    end
    // maximum legal length fills every row of every bank
    do_load("full", 4'd15, NB * DD, 0, 0, -1, 0);
    do_read("full_last", 11'd2047);
    do_read("full_first", 11'd0);
    do_read("full_mid", AW'($urandom));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
